bar_ctrl: RTL and testbench
===========================

# bar_ctrl

Barrier sequencer for the LoongArch DBAR/IBAR instructions. Sits between the issue stage and the memory/fetch subsystem. Takes the 2-bit barrier op type from the BAR decoder and holds issue until all memory ops have completed. For IBAR it also runs an I-cache invalidate handshake and a refetch flush. A barrier retires only when its ordering guarantee holds.

## Interface
- `TIMEOUT_CYCLES`, default 1024: DRAIN watchdog limit. Used only when `BAR_TIMEOUT_EN` is defined; range 2..65535.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `bar_valid` in 1: barrier instruction at the issue head. Held high until `bar_retire` or `kill`.
- `bar_op_type` in 2: `BAR_DBAR`, `BAR_IBAR` or `INVALID_OP_2B`, using the shared encodings.
- `bar_pc` in 32: PC of the barrier.
- `sb_empty` in 1: store buffer empty.
- `lsu_idle` in 1: no outstanding loads/stores.
- `ic_inv_ack` in 1: I-cache invalidate complete. One-cycle pulse.
- `kill` in 1: pipeline flush from elsewhere that squashes the barrier.
- `issue_stall` out 1: blocks younger instructions from issuing.
- `bar_busy` out 1: FSM not in IDLE.
- `bar_retire` out 1: one-cycle pulse when the barrier completes.
- `ic_inv_req` out 1: level request, held until `ic_inv_ack`.
- `flush_req` out 1: one-cycle refetch pulse (IBAR only).
- `flush_pc` out 32: refetch target, `bar_pc_q + 4` modulo 2^32.
- `bar_timeout` out 1: sticky watchdog flag.

## Operation
- **States:** IDLE, DRAIN, INV, FLUSH, DONE.
- **Captured values:** `op_q` and `bar_pc_q` are captured on accept.
- **IDLE:**
  - Accept when `bar_valid` and `bar_op_type` is DBAR or IBAR, then go to DRAIN.
  - `INVALID_OP_2B` is ignored: stay in IDLE with no stall.
- **DRAIN:** wait for `sb_empty & lsu_idle` to be high in the same cycle. Then go to DONE if `op_q` is DBAR, or to INV if IBAR.
- **INV:** `ic_inv_req` is high. On `ic_inv_ack`, go to FLUSH.
- **FLUSH:** `flush_req`=1, `bar_retire`=1, `flush_pc` valid. Go to IDLE.
- **DONE:** `bar_retire`=1. Go to IDLE.
- **`issue_stall`:** combinational. Equals `(state==IDLE & bar_valid & op valid) | state∈{DRAIN,INV}`. It is 0 in DONE and FLUSH, so issue resumes the cycle after retire.
- **`kill` in DRAIN, DONE or FLUSH:** return to IDLE next cycle. No retire or flush pulse is produced, and a kill in DONE/FLUSH suppresses that cycle's pulse.
- **`kill` in INV:** the abort is recorded in `kill_pend` and the FSM stays in INV until `ic_inv_ack`. It then goes to IDLE with no FLUSH, because an in-flight cache handshake is never abandoned.
- **`kill` and accept in the same cycle in IDLE:** kill wins. There is no accept.
- **Reset values:**
  - state=IDLE.
  - All outputs 0.
  - `flush_pc`=0.
  - `op_q`/`bar_pc_q`=0.
  - `kill_pend`=0.
  - `bar_timeout`=0.

## Timing
- **DBAR, memory already drained:**
  - Accept in cycle N.
  - DRAIN in N+1.
  - DONE/`bar_retire` in N+2.
  - Issue resumes in N+3.
  - Minimum latency is 2 cycles to retire.
- **IBAR, memory drained, ack after k cycles in INV (k≥1):** retire and flush occur in cycle N+2+k.
- **DRAIN inputs:** sampled every cycle. The condition does not need to persist.
- **INV entry:** `ic_inv_req` asserts the cycle after INV is entered and deasserts the cycle after the ack.
- **Early ack:** `ic_inv_ack` outside INV is ignored.

## Configuration
- **With `BAR_TIMEOUT_EN`:**
  - A 16-bit counter clears on DRAIN entry and increments each DRAIN cycle.
  - When it reaches `TIMEOUT_CYCLES-1` without the drain condition, the FSM proceeds as if drained.
  - On that event, `bar_timeout` sets and stays set until `rst`.
  - INV is never timed out.
- **Without it:** the counter is absent, `bar_timeout` is tied 0, and DRAIN waits indefinitely.

## Structure
- **Shared package (`defs.sv`):**
  - `bar_state_t` enum (3-bit).
  - The existing `BAR_DBAR`/`BAR_IBAR`/`INVALID_OP_2B` encodings.
  - `BAR_TIMEOUT_W`=16.
- **Sub-module `bar_drain_timer`:** the clear/increment/expire counter. It is instantiated only under `BAR_TIMEOUT_EN`.
- **FSM and capture registers:** remain in `bar_ctrl`.

## Test plan
- **DBAR, drained:** DBAR with `sb_empty`=`lsu_idle`=1 and accept at cycle 10 → `bar_retire` at cycle 12. `issue_stall` is 1 in cycles 10–11 and 0 at 12. No `flush_req`.
- **DBAR, delayed drain:** DBAR with `lsu_idle` low until cycle 20 (accept at 10) → DRAIN through cycle 20, retire at 21.
- **IBAR, `bar_pc`=0x1C000FFC:**
  - Ack 3 cycles after INV entry.
  - `ic_inv_req` high for exactly 3 cycles.
  - `flush_req`+`bar_retire` in the same cycle with `flush_pc`=0x1C001000.
  - A second run with `bar_pc`=0xFFFFFFFC → `flush_pc`=0x00000000.
- **Kill during handshake:** `kill` in INV, ack 5 cycles later → IDLE after ack. No `flush_req` and no `bar_retire`.
- **Invalid op and async reset:**
  - `bar_op_type`=`INVALID_OP_2B` with `bar_valid`=1 → `issue_stall`=0 and `bar_busy`=0.
  - Asserting `rst` mid-DRAIN → all outputs 0 immediately.
- **Watchdog (`BAR_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `sb_empty` stuck 0):** the FSM leaves DRAIN after 8 cycles, retires, and `bar_timeout` is 1 and stays 1.

Source files
------------

// File: rtl/bar_ctrl_pkg.sv
// Shared definitions for the barrier sequencer: op encodings, FSM state
// type and watchdog counter width.
package bar_ctrl_pkg;

  // Barrier op encodings produced by the BAR decoder.
  localparam logic [1:0] BAR_DBAR      = 2'b00;
  localparam logic [1:0] BAR_IBAR      = 2'b01;
  localparam logic [1:0] INVALID_OP_2B = 2'b11;

  // Width of the DRAIN watchdog counter.
  localparam int BAR_TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_INV   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } bar_state_t;

  // Only DBAR and IBAR start a barrier; every other code is ignored.
  function automatic logic is_bar_op(input logic [1:0] op);
    return (op == BAR_DBAR) || (op == BAR_IBAR);
  endfunction

endpackage

// File: rtl/bar_ctrl_if.sv
// Issue-side / memory-side signal bundle of the barrier sequencer.
// master = issue stage + memory subsystem, slave = bar_ctrl.
interface bar_ctrl_if;
  logic        bar_valid;
  logic [1:0]  bar_op_type;
  logic [31:0] bar_pc;
  logic        sb_empty;
  logic        lsu_idle;
  logic        ic_inv_ack;
  logic        kill;
  logic        issue_stall;
  logic        bar_busy;
  logic        bar_retire;
  logic        ic_inv_req;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        bar_timeout;

  modport master (
    output bar_valid, bar_op_type, bar_pc, sb_empty, lsu_idle, ic_inv_ack, kill,
    input  issue_stall, bar_busy, bar_retire, ic_inv_req, flush_req, flush_pc, bar_timeout
  );

  modport slave (
    input  bar_valid, bar_op_type, bar_pc, sb_empty, lsu_idle, ic_inv_ack, kill,
    output issue_stall, bar_busy, bar_retire, ic_inv_req, flush_req, flush_pc, bar_timeout
  );
endinterface

// File: rtl/bar_drain_timer.sv
// DRAIN watchdog counter: cleared on DRAIN entry, counts each DRAIN cycle,
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
// Only built when BAR_TIMEOUT_EN is defined.
`ifdef BAR_TIMEOUT_EN
module bar_drain_timer
  import bar_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [BAR_TIMEOUT_W-1:0] LIMIT = BAR_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [BAR_TIMEOUT_W-1:0] count_q, count_d;

  // Next count: clear wins, then saturating increment at the limit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = inc_i && (count_q == LIMIT);

endmodule
`endif

// File: rtl/bar_ctrl.sv
// Barrier sequencer for DBAR/IBAR: stalls issue until memory drains, runs
// the I-cache invalidate handshake and refetch flush for IBAR.
// Optional DRAIN watchdog enabled by defining BAR_TIMEOUT_EN.
module bar_ctrl
  import bar_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic       clk,
  input logic       rst,
  bar_ctrl_if.slave bus
);

  bar_state_t  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] bar_pc_q, bar_pc_d;
  logic        kill_pend_q, kill_pend_d;

  logic accept;
  logic drained;
  logic timeout_hit;
  logic drain_go;

  // Kill squashes a barrier in the very cycle it would be accepted.
  assign accept  = (state_q == ST_IDLE) && bus.bar_valid &&
                   is_bar_op(bus.bar_op_type) && !bus.kill;
  assign drained = bus.sb_empty && bus.lsu_idle;

`ifdef BAR_TIMEOUT_EN
  logic timer_expire;
  logic bar_timeout_q, bar_timeout_d;

  bar_drain_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .inc_i    (state_q == ST_DRAIN),
    .expire_o (timer_expire)
  );

  // A real drain takes priority; the watchdog only fires when still blocked.
  assign timeout_hit   = timer_expire && !drained;
  assign bar_timeout_d = bar_timeout_q || (timeout_hit && !bus.kill);

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_timeout_q <= 1'b0;
    end else begin
      bar_timeout_q <= bar_timeout_d;
    end
  end

  assign bus.bar_timeout = bar_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign bus.bar_timeout    = 1'b0;
`endif

  assign drain_go = drained || timeout_hit;

  // Next-state logic and capture of the accepted barrier.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bar_pc_d    = bar_pc_q;
    kill_pend_d = kill_pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_DRAIN;
          op_d     = bus.bar_op_type;
          bar_pc_d = bus.bar_pc;
        end
      end
      ST_DRAIN: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else if (drain_go) begin
          state_d = (op_q == BAR_IBAR) ? ST_INV : ST_DONE;
        end
      end
      ST_INV: begin
        // The cache handshake always completes; a kill only cancels the flush.
        if (bus.ic_inv_ack) begin
          state_d     = (kill_pend_q || bus.kill) ? ST_IDLE : ST_FLUSH;
          kill_pend_d = 1'b0;
        end else if (bus.kill) begin
          kill_pend_d = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      bar_pc_q    <= 32'h0;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bar_pc_q    <= bar_pc_d;
      kill_pend_q <= kill_pend_d;
    end
  end

  // Outputs decode from state; kill suppresses the retire/flush pulse,
  // and reset forces the combinational stall low as well.
  assign bus.issue_stall = !rst &&
                           (((state_q == ST_IDLE) && bus.bar_valid && is_bar_op(bus.bar_op_type)) ||
                            (state_q == ST_DRAIN) || (state_q == ST_INV));
  assign bus.bar_busy    = (state_q != ST_IDLE);
  assign bus.bar_retire  = ((state_q == ST_DONE) || (state_q == ST_FLUSH)) && !bus.kill;
  assign bus.flush_req   = (state_q == ST_FLUSH) && !bus.kill;
  assign bus.flush_pc    = bus.flush_req ? (bar_pc_q + 32'd4) : 32'h0;
  assign bus.ic_inv_req  = (state_q == ST_INV);

endmodule

// File: tb/tb_bar_ctrl.sv
// Self-checking bench for bar_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_bar_ctrl;
  import bar_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 8;
`ifdef BAR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bar_ctrl_if bif();

  bar_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: where the pending barrier is in its life.
  // 0 none, 1 waiting for memory, 2 waiting for cache ack, 3 retiring.
  int          m_phase;
  logic        m_ibar;
  logic [31:0] m_pc;
  logic        m_killed;
  int          m_wd;
  logic        m_to;

  logic        exp_stall, exp_busy, exp_retire, exp_req, exp_flush, exp_to;
  logic [31:0] exp_fpc;
  logic        obs_stall, obs_busy, obs_retire, obs_req, obs_flush, obs_to;
  logic [31:0] obs_fpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ibar = 0; m_pc = 0; m_killed = 0; m_wd = 0; m_to = 0;
  endtask

  task automatic model_eval();
    logic op_ok;
    op_ok      = (bif.bar_op_type == BAR_DBAR) || (bif.bar_op_type == BAR_IBAR);
    exp_busy   = (m_phase != 0);
    exp_stall  = (m_phase == 0 && bif.bar_valid && op_ok) || m_phase == 1 || m_phase == 2;
    exp_retire = (m_phase == 3) && !bif.kill;
    exp_flush  = exp_retire && m_ibar;
    exp_fpc    = exp_flush ? m_pc + 32'd4 : 32'd0;
    exp_req    = (m_phase == 2);
    exp_to     = m_to;
  endtask

  task automatic model_step();
    case (m_phase)
      0: if (bif.bar_valid && !bif.kill &&
             (bif.bar_op_type == BAR_DBAR || bif.bar_op_type == BAR_IBAR)) begin
           m_phase = 1; m_ibar = (bif.bar_op_type == BAR_IBAR); m_pc = bif.bar_pc; m_wd = 0;
         end
      1: if (bif.kill) m_phase = 0;
         else if (bif.sb_empty && bif.lsu_idle) m_phase = m_ibar ? 2 : 3;
         else if (TO_EN && m_wd == TB_TIMEOUT - 1) begin m_to = 1; m_phase = m_ibar ? 2 : 3; end
         else m_wd++;
      2: if (bif.ic_inv_ack) begin m_phase = (m_killed || bif.kill) ? 0 : 3; m_killed = 0; end
         else if (bif.kill) m_killed = 1;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"},   {31'd0, bif.issue_stall}, 0);
    chk({tag, "_busy"},    {31'd0, bif.bar_busy},    0);
    chk({tag, "_retire"},  {31'd0, bif.bar_retire},  0);
    chk({tag, "_invreq"},  {31'd0, bif.ic_inv_req},  0);
    chk({tag, "_flush"},   {31'd0, bif.flush_req},   0);
    chk({tag, "_fpc"},     bif.flush_pc,             0);
    chk({tag, "_timeout"}, {31'd0, bif.bar_timeout}, 0);
  endtask

  // One clock cycle: drive, compare DUT against the model, advance the model.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] pc,
                      input logic sb, input logic li, input logic ack, input logic kl);
    @(negedge clk);
    bif.bar_valid = v; bif.bar_op_type = op; bif.bar_pc = pc;
    bif.sb_empty = sb; bif.lsu_idle = li; bif.ic_inv_ack = ack; bif.kill = kl;
    #1;
    model_eval();
    obs_stall = bif.issue_stall; obs_busy = bif.bar_busy; obs_retire = bif.bar_retire;
    obs_req = bif.ic_inv_req; obs_flush = bif.flush_req; obs_fpc = bif.flush_pc;
    obs_to = bif.bar_timeout;
    chk("stall",   {31'd0, obs_stall},  {31'd0, exp_stall});
    chk("busy",    {31'd0, obs_busy},   {31'd0, exp_busy});
    chk("retire",  {31'd0, obs_retire}, {31'd0, exp_retire});
    chk("inv_req", {31'd0, obs_req},    {31'd0, exp_req});
    chk("flush",   {31'd0, obs_flush},  {31'd0, exp_flush});
    chk("fpc",     obs_fpc,             exp_fpc);
    chk("timeout", {31'd0, obs_to},     {31'd0, exp_to});
    if (exp_retire)
      $display("retire %s pc=%h flush_pc=%h cyc=%0d", m_ibar ? "IBAR" : "DBAR", m_pc, exp_fpc, cyc);
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  task automatic ibar_run(input logic [31:0] pc, input int k, input logic [31:0] want_fpc);
    int req_n;
    req_n = 0;
    step(1, BAR_IBAR, pc, 1, 1, 0, 0);
    step(1, BAR_IBAR, pc, 1, 1, 0, 0);
    for (int i = 1; i <= k; i++) begin
      step(1, BAR_IBAR, pc, 1, 1, (i == k), 0);
      if (obs_req) req_n++;
    end
    chk("ibar_req_cycles", req_n, k);
    step(1, BAR_IBAR, pc, 1, 1, 0, 0);
    chk("ibar_flush",  {31'd0, obs_flush},  1);
    chk("ibar_retire", {31'd0, obs_retire}, 1);
    chk("ibar_fpc",    obs_fpc, want_fpc);
    step(0, BAR_IBAR, pc, 1, 1, 0, 0);
    chk("ibar_req_off", {31'd0, obs_req},  0);
    chk("ibar_idle",    {31'd0, obs_busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int seen;
    logic        hold;
    logic [1:0]  h_op;
    logic [31:0] h_pc;
    int          h_life;
    logic        kl;

    bif.bar_valid = 0; bif.bar_op_type = INVALID_OP_2B; bif.bar_pc = 0;
    bif.sb_empty = 1; bif.lsu_idle = 1; bif.ic_inv_ack = 0; bif.kill = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // DBAR with memory already drained: accept, DRAIN, retire.
    step(1, BAR_DBAR, 32'h0000_1000, 1, 1, 0, 0);
    chk("dbar_acc_stall", {31'd0, obs_stall}, 1);
    chk("dbar_acc_busy",  {31'd0, obs_busy},  0);
    step(1, BAR_DBAR, 32'h0000_1000, 1, 1, 0, 0);
    chk("dbar_drain_stall", {31'd0, obs_stall}, 1);
    step(1, BAR_DBAR, 32'h0000_1000, 1, 1, 0, 0);
    chk("dbar_retire",       {31'd0, obs_retire}, 1);
    chk("dbar_retire_stall", {31'd0, obs_stall},  0);
    chk("dbar_no_flush",     {31'd0, obs_flush},  0);
    step(0, BAR_DBAR, 32'h0000_1000, 1, 1, 0, 0);
    chk("dbar_after_stall", {31'd0, obs_stall}, 0);

    // DBAR with lsu busy for a while: stays in DRAIN, retires after drain.
    step(1, BAR_DBAR, 32'h0000_2000, 1, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, BAR_DBAR, 32'h0000_2000, 1, 0, 0, 0);
      if (obs_stall && obs_busy && !obs_retire) seen++;
    end
    chk("dly_drain_cycles", seen, 5);
    step(1, BAR_DBAR, 32'h0000_2000, 1, 1, 0, 0);
    chk("dly_not_yet", {31'd0, obs_retire}, 0);
    step(1, BAR_DBAR, 32'h0000_2000, 0, 0, 0, 0);
    chk("dly_retire", {31'd0, obs_retire}, 1);
    step(0, BAR_DBAR, 0, 1, 1, 0, 0);

    // IBAR flush target, including 32-bit wraparound.
    ibar_run(32'h1C00_0FFC, 3, 32'h1C00_1000);
    ibar_run(32'hFFFF_FFFC, 2, 32'h0000_0000);

    // Kill in INV: handshake completes, no flush, no retire.
    step(1, BAR_IBAR, 32'h0000_3000, 1, 1, 0, 0);
    step(1, BAR_IBAR, 32'h0000_3000, 1, 1, 0, 0);
    seen = 0;
    step(1, BAR_IBAR, 32'h0000_3000, 1, 1, 0, 1);
    seen += obs_flush + obs_retire;
    for (int i = 0; i < 4; i++) begin
      step(0, BAR_IBAR, 0, 1, 1, 0, 0);
      seen += obs_flush + obs_retire;
      chk("kill_inv_hold_req", {31'd0, obs_req}, 1);
    end
    step(0, BAR_IBAR, 0, 1, 1, 1, 0);
    seen += obs_flush + obs_retire;
    step(0, BAR_IBAR, 0, 1, 1, 0, 0);
    seen += obs_flush + obs_retire;
    chk("kill_inv_no_pulse", seen, 0);
    chk("kill_inv_idle", {31'd0, obs_busy}, 0);

    // Invalid op is ignored.
    step(1, INVALID_OP_2B, 32'h0000_4000, 1, 1, 0, 0);
    chk("inval_stall", {31'd0, obs_stall}, 0);
    step(1, INVALID_OP_2B, 32'h0000_4000, 1, 1, 0, 0);
    chk("inval_busy", {31'd0, obs_busy}, 0);
    step(0, INVALID_OP_2B, 0, 1, 1, 0, 0);

    // Asynchronous reset while in DRAIN.
    step(1, BAR_DBAR, 32'h0000_5000, 0, 1, 0, 0);
    step(1, BAR_DBAR, 32'h0000_5000, 0, 1, 0, 0);
    chk("pre_rst_busy", {31'd0, obs_busy}, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid_drain");
    model_reset();
    @(negedge clk);
    bif.bar_valid = 0;
    rst = 1'b0;

`ifdef BAR_TIMEOUT_EN
    // Watchdog: sb_empty stuck low, DRAIN exits after TB_TIMEOUT cycles.
    step(1, BAR_DBAR, 32'h0000_6000, 0, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 50 && !obs_retire; i++) begin
      step(1, BAR_DBAR, 32'h0000_6000, 0, 1, 0, 0);
      if (obs_busy && obs_stall) seen++;
    end
    chk("wd_drain_cycles", seen, TB_TIMEOUT);
    chk("wd_retire", {31'd0, obs_retire}, 1);
    chk("wd_flag",   {31'd0, obs_to},     1);
    step(0, BAR_DBAR, 0, 1, 1, 0, 0);
    step(0, BAR_DBAR, 0, 1, 1, 0, 0);
    chk("wd_sticky", {31'd0, obs_to}, 1);
`endif

    // Randomized traffic following the bar_valid hold protocol.
    hold = 0; h_op = BAR_DBAR; h_pc = 0; h_life = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold && $urandom_range(0, 2) == 0) begin
        hold   = 1;
        h_op   = 2'($urandom_range(0, 3));
        h_pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        h_life = $urandom_range(1, 4);
      end
      kl = ($urandom_range(0, 24) == 0);
      step(hold, h_op, h_pc,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), kl);
      if (hold) begin
        if (exp_retire || kl) hold = 0;
        else if (!(h_op == BAR_DBAR || h_op == BAR_IBAR)) begin
          h_life--;
          if (h_life == 0) hold = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
